// File: rtl/eth_flow_ctrl.sv
// Purpose: per-channel Ethernet pause-frame request generator driven by MAC RX FIFO level flags.
// Latency: one cycle; a flag sampled at rising edge N shows on xoff_gen/xon_gen/paused after edge N+1.
// Backpressure: none; level flags are sampled every cycle and pulses are single-cycle, never held.
module eth_flow_ctrl #(
   parameter int NUM_CH         = 2,
   parameter int REFRESH_CYCLES = 65535,
   parameter int HOLDOFF_CYCLES = 256
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [NUM_CH-1:0]     ch_enable,
   input  logic [NUM_CH-1:0]     ff_rx_a_full,
   input  logic [NUM_CH-1:0]     ff_rx_a_empty,
   output logic [NUM_CH-1:0]     xoff_gen,
   output logic [NUM_CH-1:0]     xon_gen,
   output logic [NUM_CH-1:0]     paused,
   output logic [16*NUM_CH-1:0]  xoff_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [15:0] REFRESH_LOAD = 16'(REFRESH_CYCLES - 1);
   localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF_CYCLES - 1);

   state_t      state [NUM_CH];
   logic [15:0] cnt   [NUM_CH];

   // Saturating +1 so a long-paused channel parks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // One FSM per channel; the shared down-counter times either the XOFF refresh
   // interval (PAUSED) or the minimum quiet time after an XON (HOLD).
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= ST_RUN;
            cnt[i]   <= 16'd0;
         end
         xoff_gen   <= '0;
         xon_gen    <= '0;
         paused     <= '0;
         xoff_count <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            xoff_gen[i] <= 1'b0;
            xon_gen[i]  <= 1'b0;
            case (state[i])
               ST_RUN: begin
                  // a_full wins over a_empty here: only a_full is looked at in RUN.
                  if (ch_enable[i] && ff_rx_a_full[i]) begin
                     xoff_gen[i]           <= 1'b1;
                     paused[i]             <= 1'b1;
                     state[i]              <= ST_PAUSED;
                     cnt[i]                <= REFRESH_LOAD;
                     xoff_count[16*i +: 16] <= sat_inc(xoff_count[16*i +: 16]);
                  end
               end
               ST_PAUSED: begin
                  // Disable and drain both release the link; either beats a due refresh.
                  if (!ch_enable[i] || ff_rx_a_empty[i]) begin
                     xon_gen[i] <= 1'b1;
                     paused[i]  <= 1'b0;
                     state[i]   <= ST_HOLD;
                     cnt[i]     <= HOLDOFF_LOAD;
                  end else if (cnt[i] == 16'd0) begin
                     xoff_gen[i]           <= 1'b1;
                     cnt[i]                <= REFRESH_LOAD;
                     xoff_count[16*i +: 16] <= sat_inc(xoff_count[16*i +: 16]);
                  end else begin
                     cnt[i] <= cnt[i] - 16'd1;
                  end
               end
               ST_HOLD: begin
                  // No XOFF may issue here; RUN is re-entered once the hold-off expires.
                  if (cnt[i] == 16'd0) begin
                     state[i] <= ST_RUN;
                  end else begin
                     cnt[i] <= cnt[i] - 16'd1;
                  end
               end
               default: begin
                  state[i]  <= ST_RUN;
                  paused[i] <= 1'b0;
                  cnt[i]    <= 16'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eth_flow_ctrl.sv
// Directed bench for eth_flow_ctrl with NUM_CH=2, REFRESH_CYCLES=8, HOLDOFF_CYCLES=4.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
// obs packs {xoff_gen[1:0], xon_gen[1:0], paused[1:0]}.
module tb_eth_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  en;
   logic [1:0]  full;
   logic [1:0]  empty;
   logic [1:0]  xoff_gen;
   logic [1:0]  xon_gen;
   logic [1:0]  paused;
   logic [31:0] xoff_count;
   logic [5:0]  obs;

   int n_cmp = 0;
   int n_err = 0;

   assign obs = {xoff_gen, xon_gen, paused};

   always #5 clk = ~clk;

   eth_flow_ctrl #(
      .NUM_CH         (2),
      .REFRESH_CYCLES (8),
      .HOLDOFF_CYCLES (4)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .ch_enable     (en),
      .ff_rx_a_full  (full),
      .ff_rx_a_empty (empty),
      .xoff_gen      (xoff_gen),
      .xon_gen       (xon_gen),
      .paused        (paused),
      .xoff_count    (xoff_count)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 2'b00; full = 2'b00; empty = 2'b00;
      repeat (3) tick;
      n_cmp++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL reset_outputs got=%b want=%b", obs, 6'b000000); end
      n_cmp++;
      if (xoff_count !== 32'd0) begin n_err++; $display("FAIL reset_count got=%h want=%h", xoff_count, 32'd0); end
      en = 2'b11; full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL reset_full_held got=%b want=%b", obs, 6'b000000); end
      rst_n = 1'b1; full = 2'b00;
      tick;
      n_cmp++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL release_idle got=%b want=%b", obs, 6'b000000); end
   endtask

   task automatic test_xoff;
      full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL xoff_first got=%b want=%b", obs, 6'b010001); end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd1}) begin n_err++; $display("FAIL xoff_first_count got=%h want=%h", xoff_count, {16'd0, 16'd1}); end
      full = 2'b00;
      tick;
      n_cmp++;
      if (obs !== 6'b000001) begin n_err++; $display("FAIL xoff_one_wide got=%b want=%b", obs, 6'b000001); end
   endtask

   task automatic test_refresh;
      for (int k = 2; k <= 24; k++) begin
         logic [5:0] exp;
         tick;
         exp = ((k % 8) == 0) ? 6'b010001 : 6'b000001;
         n_cmp++;
         if (obs !== exp) begin n_err++; $display("FAIL refresh k=%0d got=%b want=%b", k, obs, exp); end
      end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd4}) begin n_err++; $display("FAIL refresh_count got=%h want=%h", xoff_count, {16'd0, 16'd4}); end
   endtask

   task automatic test_xon_holdoff;
      full = 2'b01; empty = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b000100) begin n_err++; $display("FAIL xon_pulse got=%b want=%b", obs, 6'b000100); end
      for (int t = 1; t <= 4; t++) begin
         tick;
         n_cmp++;
         if (obs !== 6'b000000) begin n_err++; $display("FAIL holdoff t=%0d got=%b want=%b", t, obs, 6'b000000); end
      end
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL xoff_after_hold got=%b want=%b", obs, 6'b010001); end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd5}) begin n_err++; $display("FAIL hold_count got=%h want=%h", xoff_count, {16'd0, 16'd5}); end
      tick;
      n_cmp++;
      if (obs !== 6'b000100) begin n_err++; $display("FAIL xon_again got=%b want=%b", obs, 6'b000100); end
      full = 2'b00; empty = 2'b00;
      repeat (5) tick;
      n_cmp++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL back_to_run got=%b want=%b", obs, 6'b000000); end
   endtask

   task automatic test_coincide;
      full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL coin_xoff got=%b want=%b", obs, 6'b010001); end
      full = 2'b00;
      for (int t = 1; t <= 7; t++) begin
         tick;
         n_cmp++;
         if (obs !== 6'b000001) begin n_err++; $display("FAIL coin_wait t=%0d got=%b want=%b", t, obs, 6'b000001); end
      end
      empty = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b000100) begin n_err++; $display("FAIL coin_empty_wins got=%b want=%b", obs, 6'b000100); end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd6}) begin n_err++; $display("FAIL coin_count got=%h want=%h", xoff_count, {16'd0, 16'd6}); end
      empty = 2'b00;
      repeat (5) tick;
   endtask

   task automatic test_disable;
      full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL dis_xoff got=%b want=%b", obs, 6'b010001); end
      en = 2'b10; empty = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b000100) begin n_err++; $display("FAIL dis_xon got=%b want=%b", obs, 6'b000100); end
      empty = 2'b00;
      for (int t = 1; t <= 10; t++) begin
         tick;
         n_cmp++;
         if (obs !== 6'b000000) begin n_err++; $display("FAIL dis_quiet t=%0d got=%b want=%b", t, obs, 6'b000000); end
      end
      en = 2'b11;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL dis_reenable got=%b want=%b", obs, 6'b010001); end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd8}) begin n_err++; $display("FAIL dis_count got=%h want=%h", xoff_count, {16'd0, 16'd8}); end
      full = 2'b00;
   endtask

   task automatic test_async_reset;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 6'b000000) begin n_err++; $display("FAIL arst_outputs got=%b want=%b", obs, 6'b000000); end
      n_cmp++;
      if (xoff_count !== 32'd0) begin n_err++; $display("FAIL arst_count got=%h want=%h", xoff_count, 32'd0); end
      full = 2'b01;
      for (int t = 1; t <= 3; t++) begin
         tick;
         n_cmp++;
         if (obs !== 6'b000000) begin n_err++; $display("FAIL arst_hold t=%0d got=%b want=%b", t, obs, 6'b000000); end
      end
      full = 2'b00;
      rst_n = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         tick;
         n_cmp++;
         if (obs !== 6'b000000) begin n_err++; $display("FAIL arst_release t=%0d got=%b want=%b", t, obs, 6'b000000); end
      end
      full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL arst_first_xoff got=%b want=%b", obs, 6'b010001); end
      n_cmp++;
      if (xoff_count !== {16'd0, 16'd1}) begin n_err++; $display("FAIL arst_first_count got=%h want=%h", xoff_count, {16'd0, 16'd1}); end
      full = 2'b00;
   endtask

   task automatic test_channels;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      en = 2'b11; full = 2'b11;
      tick;
      n_cmp++;
      if (obs !== 6'b110011) begin n_err++; $display("FAIL chan_xoff got=%b want=%b", obs, 6'b110011); end
      n_cmp++;
      if (xoff_count !== {16'd1, 16'd1}) begin n_err++; $display("FAIL chan_count got=%h want=%h", xoff_count, {16'd1, 16'd1}); end
      full = 2'b00;
      tick;
      n_cmp++;
      if (obs !== 6'b000011) begin n_err++; $display("FAIL chan_paused got=%b want=%b", obs, 6'b000011); end
      empty = 2'b11;
      tick;
      n_cmp++;
      if (obs !== 6'b001100) begin n_err++; $display("FAIL chan_xon got=%b want=%b", obs, 6'b001100); end
      empty = 2'b00;
      repeat (5) tick;
   endtask

   task automatic test_saturate;
      force dut.xoff_count = {16'd1, 16'hFFFE};
      tick;
      release dut.xoff_count;
      tick;
      n_cmp++;
      if (xoff_count !== {16'd1, 16'hFFFE}) begin n_err++; $display("FAIL sat_preload got=%h want=%h", xoff_count, {16'd1, 16'hFFFE}); end
      full = 2'b01;
      tick;
      n_cmp++;
      if (obs !== 6'b010001) begin n_err++; $display("FAIL sat_xoff1 got=%b want=%b", obs, 6'b010001); end
      n_cmp++;
      if (xoff_count !== {16'd1, 16'hFFFF}) begin n_err++; $display("FAIL sat_count1 got=%h want=%h", xoff_count, {16'd1, 16'hFFFF}); end
      full = 2'b00;
      for (int r = 2; r <= 3; r++) begin
         repeat (7) tick;
         tick;
         n_cmp++;
         if (obs !== 6'b010001) begin n_err++; $display("FAIL sat_xoff%0d got=%b want=%b", r, obs, 6'b010001); end
         n_cmp++;
         if (xoff_count !== {16'd1, 16'hFFFF}) begin n_err++; $display("FAIL sat_count%0d got=%h want=%h", r, xoff_count, {16'd1, 16'hFFFF}); end
      end
      repeat (3) tick;
      n_cmp++;
      if (xoff_count !== {16'd1, 16'hFFFF}) begin n_err++; $display("FAIL sat_hold got=%h want=%h", xoff_count, {16'd1, 16'hFFFF}); end
   endtask

   initial begin
      test_reset;
      test_xoff;
      test_refresh;
      test_xon_holdoff;
      test_coincide;
      test_disable;
      test_async_reset;
      test_channels;
      test_saturate;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/eth_flow_ctrl.md
ETH_FLOW_CTRL -- requirements
Module: eth_flow_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_clk and reset_reset_n.
REQ-002 Parameter NUM_CH, default 2: number of independent MAC channels (1..8).
REQ-003 Parameter REFRESH_CYCLES, default 65535: cycles between repeated XOFF requests while a channel stays paused (2..65535).
REQ-004 Parameter HOLDOFF_CYCLES, default 256: minimum cycles after an XON before the next XOFF is allowed (1..65535).
REQ-005 Port: clk_clk  input  1  system clock; all other inputs are synchronous to it.
REQ-006 Port: reset_reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: ch_enable  input  NUM_CH  per-channel flow-control enable.
REQ-008 Port: ff_rx_a_full  input  NUM_CH  MAC RX FIFO almost-full level flag.
REQ-009 Port: ff_rx_a_empty  input  NUM_CH  MAC RX FIFO almost-empty level flag.
REQ-010 Port: xoff_gen  output  NUM_CH  one-cycle pause-request pulse to the MAC.
REQ-011 Port: xon_gen  output  NUM_CH  one-cycle pause-release pulse to the MAC.
REQ-012 Port: paused  output  NUM_CH  high while the channel is in PAUSED.
REQ-013 Port: xoff_count  output  16*NUM_CH  per-channel saturating XOFF pulse count; channel i in bits [16*i+15:16*i].

Function
REQ-014 Each channel SHALL run an independent FSM with states RUN, PAUSED and HOLD, plus one down-counter 16 bits wide, shared by refresh and hold-off.
REQ-015 All outputs SHALL be registered: an input sampled at rising edge N affects outputs from edge N+1.
REQ-016 RUN: if ch_enable and ff_rx_a_full are high, the channel SHALL pulse xoff_gen, enter PAUSED and load the counter with REFRESH_CYCLES-1.
REQ-017 PAUSED: if ff_rx_a_empty is high, the channel SHALL pulse xon_gen, enter HOLD and load the counter with HOLDOFF_CYCLES-1.
REQ-018 PAUSED: otherwise, when the counter reaches 0, the channel SHALL pulse xoff_gen again (refresh), stay in PAUSED and reload REFRESH_CYCLES-1; otherwise it decrements.
REQ-019 PAUSED: if ch_enable goes low, the channel SHALL pulse xon_gen and enter HOLD; this takes priority over the a_empty and refresh rules.
REQ-020 HOLD: the counter SHALL decrement each cycle, and the channel SHALL enter RUN in the cycle after the counter reaches 0; xoff_gen SHALL NOT assert in HOLD.
REQ-021 If a_full is high on the HOLD-to-RUN transition, XOFF SHALL issue one cycle later under the RUN rule.
REQ-022 If a_full and a_empty are both high in RUN, a_full SHALL win.
REQ-023 If a_empty and the refresh expiry coincide in PAUSED, a_empty SHALL win, with no XOFF that cycle.
REQ-024 xoff_gen and xon_gen SHALL never be high together on one channel, and each is at most one cycle wide.
REQ-025 paused SHALL be high exactly while the FSM is in PAUSED.
REQ-026 xoff_count SHALL increment on every xoff_gen pulse, including refreshes, and SHALL saturate at 16'hFFFF.
REQ-027 Channels SHALL NOT interact; identical stimulus on two channels SHALL give identical outputs in the same cycles.

Reset
REQ-028 While reset_reset_n is low, every channel SHALL be in RUN with the counter at 0, and xoff_gen, xon_gen, paused and xoff_count SHALL all be 0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately without emitting an xon_gen pulse.
REQ-030 The first xoff_gen after reset release SHALL require a_full to be sampled high on an edge after release.

Verification (NUM_CH=2, REFRESH_CYCLES=8, HOLDOFF_CYCLES=4)
REQ-031 Ch0 a_full high at edge 10 -> xoff_gen[0] high in cycle 11 only, paused[0]=1 from cycle 11, xoff_count[15:0]=1; ch1 outputs stay 0.
REQ-032 Ch0 held paused, a_empty low -> refresh xoff_gen[0] pulses in cycles 19, 27 and 35; xoff_count=4 after cycle 35.
REQ-033 Ch0 paused, a_empty high at edge 14 -> xon_gen[0] in cycle 15; a_full held high -> next xoff_gen[0] in cycle 20.
REQ-034 Ch0 paused, ch_enable[0] low and a_empty high in the same cycle -> exactly one xon_gen pulse, then HOLD, then RUN; no XOFF while enable is low.
REQ-035 Reset asserted mid-PAUSED -> all outputs 0 asynchronously; after release, no pulse until a_full is sampled high.
REQ-036 Force xoff_count[15:0] to 16'hFFFE, then cause 3 XOFFs -> count reads 16'hFFFF and holds.
